// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplication is shift-add (MUL_BITS multiplier bits per cycle). Division
// is restoring (one quotient bit per cycle). Both work on magnitudes, and the
// sign is fixed up in a final FIX cycle. MADD/MSUB accumulate into {hi,lo}.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; MTHI/MTLO write hi/lo directly here
// PREP     | take operand magnitudes, load accumulator and iteration counter
// MUL_ITER | shift-add, MUL_BITS multiplier bits retired per cycle
// DIV_ITER | restoring divide, one quotient bit per cycle
// FIX      | sign correction / accumulation, write hi/lo, raise done
module iter_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MUL_N = WIDTH / MUL_BITS;
  localparam int DIV_N = WIDTH;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int PW    = WIDTH + MUL_BITS;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL_ITER,
    S_DIV_ITER,
    S_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               is_signed;
  logic               is_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [PW-1:0]      pp;
  logic [PW-1:0]      mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // State and datapath registers; reset clears everything including the counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state logic; cancel wins over everything, including start in IDLE
  always_comb begin
    state_d = state_q;
    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (start && op != OP_MTHI && op != OP_MTLO) state_d = S_PREP;
        S_PREP:     state_d = is_div ? S_DIV_ITER : S_MUL_ITER;
        S_MUL_ITER: if (cnt_q == '0) state_d = S_FIX;
        S_DIV_ITER: if (cnt_q == '0) state_d = S_FIX;
        S_FIX:      state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Per-iteration arithmetic and final sign fix-up values
  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // upper half stays below 2^WIDTH, so the sum never exceeds PW bits
    pp        = PW'(opnd_q) * PW'(acc_q[MUL_BITS-1:0]);
    mul_sum   = PW'(acc_q[2*WIDTH-1:WIDTH]) + pp;
    mul_next  = {mul_sum, acc_q[WIDTH-1:MUL_BITS]};

    // acc holds {remainder, dividend-shifting-into-quotient}
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod    = neg_q ? -acc_q : acc_q;
    quo_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Datapath register updates; cancel freezes hi/lo/div_zero and kills done
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    dz_d   = dz_q;
    if (!cancel) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi_d = src_a;
            end else if (op == OP_MTLO) begin
              lo_d = src_a;
            end else begin
              op_d = op;
              a_d  = src_a;
              b_d  = src_b;
            end
          end
        end
        S_PREP: begin
          neg_d  = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d = is_signed & a_q[WIDTH-1];
          if (is_div) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            cnt_d  = CW'(DIV_N - 1);
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            cnt_d  = CW'(MUL_N - 1);
          end
        end
        S_MUL_ITER, S_DIV_ITER: begin
          acc_d = (state_q == S_DIV_ITER) ? div_next : mul_next;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
        S_FIX: begin
          done_d = 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod;
            OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - prod;
            OP_DIV, OP_DIVU: begin
              if (b_q == '0) begin
                lo_d = '1;
                hi_d = a_q;
                dz_d = 1'b1;
              end else begin
                lo_d = quo_fix;
                hi_d = rem_fix;
                dz_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand/HI/LO width; SHALL be even and >= 8.
REQ-002 Parameter MUL_BITS, default 1: multiplier bits retired per iteration; SHALL be 1 or 2 and divide WIDTH.
REQ-003 clk  in  1  sole clock; all state SHALL change only on its rising edge.
REQ-004 reset_n  in  1  one clock; reset is synchronous and active-low.
REQ-005 start  in  1  op request, sampled each edge.
REQ-006 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-007 src_a  in  WIDTH  rs operand (dividend / multiplicand / MTxx data).
REQ-008 src_b  in  WIDTH  rt operand (divisor / multiplier).
REQ-009 cancel  in  1  pipeline flush; aborts the in-flight op.
REQ-010 busy  out  1  high while state != IDLE.
REQ-011 done  out  1  one-cycle pulse on completion of an iterative op.
REQ-012 div_zero  out  1  divisor was zero on the last completed DIV/DIVU.
REQ-013 hi, lo  out  WIDTH  architectural HI/LO registers.

Function
REQ-014 States SHALL be IDLE, PREP, MUL_ITER, DIV_ITER, FIX.
REQ-015 In IDLE with start and op 0-3 or 6-7, the unit SHALL latch operands and op, then enter PREP on that edge.
REQ-016 PREP (1 cycle) SHALL take absolute values for signed ops, then enter MUL_ITER (ops 0,1,6,7) or DIV_ITER (ops 2,3).
REQ-017 MUL_ITER SHALL last WIDTH/MUL_BITS cycles (shift-add); DIV_ITER SHALL last WIDTH cycles (restoring, 1 quotient bit per cycle); a down-counter SHALL track iterations.
REQ-018 FIX (1 cycle) SHALL apply sign correction and accumulation, write hi/lo, and return to IDLE; done SHALL be high in the following cycle only.
REQ-019 busy SHALL be high for exactly N+2 cycles after acceptance (N = iteration count): 34 for WIDTH=32 MULT/DIV at MUL_BITS=1, 18 for MULT at MUL_BITS=2.
REQ-020 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-021 MADD/MSUB: {hi,lo} = {hi,lo} +/- signed product, wrapping modulo 2^(2*WIDTH); {hi,lo} SHALL be sampled at FIX.
REQ-022 DIV: quotient truncated toward zero to lo; remainder to hi, taking the dividend's sign; DIVU unsigned.
REQ-023 Divisor zero: lo = all ones, hi = src_a, div_zero = 1; latency unchanged; div_zero SHALL clear at the next completed DIV/DIVU.
REQ-024 DIV of most-negative by -1: lo = most-negative, hi = 0, div_zero = 0.
REQ-025 MTHI/MTLO in IDLE SHALL write hi/lo on the same edge, leave busy low, and raise no done.
REQ-026 start while busy (any op) SHALL be ignored with no side effect.
REQ-027 cancel SHALL force IDLE on the next edge, leave hi/lo/div_zero unchanged, and suppress done; cancel SHALL beat start in the same cycle, including in IDLE.
REQ-028 A cancel arriving in the cycle done is high SHALL NOT undo the completed write.

Reset
REQ-029 reset_n low at an edge SHALL set state IDLE, hi = lo = 0, done = 0, div_zero = 0, busy = 0, counter 0, mid-operation included, overriding start and cancel.

Verification
REQ-030 WIDTH=32, MULT a=0xFFFFFFFE, b=3 -> busy 34 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for 1 cycle.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_zero=1.
REQ-032 MTHI 5, MTLO 0, then MADD 2*3 -> hi=5, lo=6; from hi=lo=0, MSUB 1*1 -> hi=lo=0xFFFFFFFF.
REQ-033 DIVU issued, cancel at iteration 10, start+MULT issued during busy -> busy low next cycle, hi/lo unchanged, no done, MULT never executed.
REQ-034 reset_n low mid-MULT -> next cycle hi=lo=0, busy=0, done=0; MUL_BITS=2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> 18 busy cycles, hi=0xFFFFFFFE, lo=1.
